// File: rtl/pb_mcast_dst_iter_pkg.sv
// Shared types for the multicast destination iterator.
// Coordinate ids, mask field selectors and iterator FSM states.
package pb_mcast_dst_iter_pkg;

  localparam int IdXWidth = 3;
  localparam int IdYWidth = 3;

  typedef struct packed {
    logic [IdXWidth-1:0] x;
    logic [IdYWidth-1:0] y;
  } id_t;

  localparam int FieldXLen = 2;
  localparam int FieldYLen = 2;

  typedef struct packed {
    logic [FieldXLen-1:0] x;
    logic [FieldYLen-1:0] y;
  } mcast_field_t;

  typedef struct packed {
    int unsigned offset;
    int unsigned len;
  } mask_sel_t;

  typedef struct packed {
    mask_sel_t x;
    mask_sel_t y;
  } mcast_sel_t;

  typedef enum logic {
    ST_IDLE,
    ST_SCAN
  } state_e;

  // X/Y selectors of the cluster rule 0 in the multicast SAM
  function automatic mcast_sel_t rule0_mcast_sel();
    mcast_sel_t s;
    s.x.offset = 20;
    s.x.len    = 2;
    s.y.offset = 18;
    s.y.len    = 2;
    return s;
  endfunction

  localparam mcast_sel_t Rule0Sel = rule0_mcast_sel();

endpackage

// File: rtl/pb_mcast_dst_iter_subset_cnt.sv
// Masked-subset counter: walks every subset of the set bits of mask.
// wrap flags that the current subset equals the full mask.
module pb_mcast_subset_cnt #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clear,
  input  logic         advance,
  input  logic [W-1:0] mask,
  output logic [W-1:0] sub,
  output logic         wrap
);

  logic [W-1:0] sub_n;

  // Forcing non-mask bits to 1 lets the carry skip over them
  assign sub_n = ((sub | ~mask) + W'(1)) & mask;
  assign wrap  = (sub == mask);

  always_ff @(posedge clk_i) begin
    if (rst_i || clear) begin
      sub <= '0;
    end else if (advance) begin
      sub <= sub_n;
    end
  end

endmodule

// File: rtl/pb_mcast_dst_iter.sv
// Expands a multicast address+mask into a serial unicast stream.
// A one-entry holdback makes dst_last_o exact past trailing holes.
module pb_mcast_dst_iter
  import pb_mcast_dst_iter_pkg::*;
#(
  parameter int AddrWidth = 48,
  parameter int XOffset   = int'(Rule0Sel.x.offset),
  parameter int XLen      = int'(Rule0Sel.x.len),
  parameter int YOffset   = int'(Rule0Sel.y.offset),
  parameter int YLen      = int'(Rule0Sel.y.len),
  parameter int NumX      = 4,
  parameter int NumY      = 3,
  parameter int XBase     = 1,
  parameter int YBase     = 0
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [AddrWidth-1:0] req_addr_i,
  input  logic [AddrWidth-1:0] req_mask_i,
  output logic                 dst_valid_o,
  input  logic                 dst_ready_i,
  output logic [IdXWidth-1:0]  dst_x_o,
  output logic [IdYWidth-1:0]  dst_y_o,
  output logic [AddrWidth-1:0] dst_addr_o,
  output logic                 dst_last_o,
  output logic                 empty_o
);

  localparam int FW = XLen + YLen;

  state_e state, state_n;

  logic [FW-1:0] req_f, req_m;
  logic [FW-1:0] base, m, pend, cand, sub;
  logic [AddrWidth-1:0] addr;
  logic pend_v, scan_done;
  logic in_range, wrap, adv, accept;
  logic [XLen-1:0] cand_x, pend_x;
  logic [YLen-1:0] cand_y, pend_y;
  logic unused_mask;

  assign req_f = {req_addr_i[XOffset+:XLen],
                  req_addr_i[YOffset+:YLen]};
  assign req_m = {req_mask_i[XOffset+:XLen],
                  req_mask_i[YOffset+:YLen]};
  assign unused_mask = ^req_mask_i;

  assign cand   = (base & ~m) | sub;
  assign cand_x = cand[FW-1-:XLen];
  assign cand_y = cand[YLen-1:0];
  assign pend_x = pend[FW-1-:XLen];
  assign pend_y = pend[YLen-1:0];

  assign in_range =
    ({1'b0, cand_x} < (XLen+1)'(NumX)) &&
    ({1'b0, cand_y} < (YLen+1)'(NumY));

  assign accept = (state == ST_IDLE) && req_valid_i;

  pb_mcast_subset_cnt #(
    .W(FW)
  ) u_cnt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clear  (accept),
    .advance(adv),
    .mask   (m),
    .sub    (sub),
    .wrap   (wrap)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      ST_IDLE: if (req_valid_i) state_n = ST_SCAN;
      ST_SCAN: begin
        if (scan_done && (!pend_v || dst_ready_i)) begin
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = (state == ST_IDLE);
    dst_valid_o = 1'b0;
    dst_last_o  = 1'b0;
    empty_o     = 1'b0;
    adv         = 1'b0;
    if (state == ST_SCAN) begin
      if (scan_done) begin
        dst_valid_o = pend_v;
        dst_last_o  = pend_v;
        empty_o     = !pend_v;
      end else if (pend_v && in_range) begin
        dst_valid_o = 1'b1;
        adv         = dst_ready_i;
      end else begin
        adv = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base      <= '0;
      m         <= '0;
      pend      <= '0;
      addr      <= '0;
      pend_v    <= 1'b0;
      scan_done <= 1'b0;
    end else if (accept) begin
      base      <= req_f;
      m         <= req_m;
      addr      <= req_addr_i;
      pend_v    <= 1'b0;
      scan_done <= 1'b0;
    end else if (state == ST_SCAN) begin
      if (adv) begin
        if (in_range) begin
          pend   <= cand;
          pend_v <= 1'b1;
        end
        if (wrap) scan_done <= 1'b1;
      end
      if (scan_done && dst_ready_i) pend_v <= 1'b0;
    end
  end

  always_comb begin
    dst_x_o    = '0;
    dst_y_o    = '0;
    dst_addr_o = '0;
    if (dst_valid_o) begin
      dst_x_o = IdXWidth'(pend_x) + IdXWidth'(XBase);
      dst_y_o = IdYWidth'(pend_y) + IdYWidth'(YBase);
      dst_addr_o = addr;
      dst_addr_o[XOffset+:XLen] = pend_x;
      dst_addr_o[YOffset+:YLen] = pend_y;
    end
  end

endmodule

// File: tb/tb_pb_mcast_dst_iter.sv
// Scoreboard bench for pb_mcast_dst_iter.
// Directed requests push expected beats; a monitor pops and compares.
module tb_pb_mcast_dst_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [47:0] req_addr;
  logic [47:0] req_mask;
  logic        dst_valid;
  logic        dst_ready;
  logic [2:0]  dst_x;
  logic [2:0]  dst_y;
  logic [47:0] dst_addr;
  logic        dst_last;
  logic        empty;

  always #5 clk = ~clk;

  pb_mcast_dst_iter dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .req_valid_i(req_valid),
    .req_ready_o(req_ready),
    .req_addr_i (req_addr),
    .req_mask_i (req_mask),
    .dst_valid_o(dst_valid),
    .dst_ready_i(dst_ready),
    .dst_x_o    (dst_x),
    .dst_y_o    (dst_y),
    .dst_addr_o (dst_addr),
    .dst_last_o (dst_last),
    .empty_o    (empty)
  );

  typedef struct {
    bit          is_empty;
    logic [2:0]  x;
    logic [2:0]  y;
    logic [47:0] addr;
    bit          last;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int beats = 0;
  int empties = 0;

  localparam logic [47:0] BaseAddr = 48'h8000_0000_0123;
  localparam logic [47:0] MaskY    = 48'h00_000C_0000;
  localparam logic [47:0] MaskXY   = 48'h00_003C_0000;

  function automatic logic [47:0] mk(int fx, int fy);
    logic [47:0] a;
    a = BaseAddr;
    a[21:20] = fx[1:0];
    a[19:18] = fy[1:0];
    return a;
  endfunction

  task automatic chk(string nm, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic push_beat(int fx, int fy, bit last);
    exp_t e;
    e.is_empty = 1'b0;
    e.x = 3'(fx + 1);
    e.y = 3'(fy);
    e.addr = mk(fx, fy);
    e.last = last;
    q.push_back(e);
  endtask

  task automatic push_empty();
    exp_t e;
    e.is_empty = 1'b1;
    e.x = '0;
    e.y = '0;
    e.addr = '0;
    e.last = 1'b0;
    q.push_back(e);
  endtask

  task automatic push_full();
    for (int fx = 0; fx < 4; fx++)
      for (int fy = 0; fy < 3; fy++)
        push_beat(fx, fy, (fx == 3) && (fy == 2));
  endtask

  // Monitor: stability, pulse width and scoreboard pops
  logic        stall_prev = 1'b0;
  logic        empty_prev = 1'b0;
  logic [2:0]  px, py;
  logic [47:0] pa;
  logic        pl;

  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
      empty_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("stall_valid", dst_valid, 1);
        chk("stall_x", dst_x, px);
        chk("stall_y", dst_y, py);
        chk("stall_addr", dst_addr, pa);
        chk("stall_last", dst_last, pl);
      end
      if (empty_prev) begin
        chk("empty_one_cycle", empty, 0);
        chk("ready_after_empty", req_ready, 1);
      end
      if (dst_valid) chk("ready_busy", req_ready, 0);
      if (dst_valid && dst_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_beat", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("beat_kind", e.is_empty, 0);
          chk("beat_x", dst_x, e.x);
          chk("beat_y", dst_y, e.y);
          chk("beat_addr", dst_addr, e.addr);
          chk("beat_last", dst_last, e.last);
        end
        beats++;
      end
      if (empty) begin
        if (q.size() == 0) begin
          chk("unexpected_empty", 1, 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("empty_kind", e.is_empty, 1);
        end
        chk("empty_no_valid", dst_valid, 0);
        empties++;
      end
      stall_prev = dst_valid && !dst_ready;
      empty_prev = empty;
      px = dst_x;
      py = dst_y;
      pa = dst_addr;
      pl = dst_last;
    end
  end

  task automatic send(logic [47:0] a, logic [47:0] msk);
    int n;
    n = 0;
    while (!req_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 200) chk("send_timeout", 1, 0);
    req_addr  = a;
    req_mask  = msk;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle(bit rnd);
    int n;
    n = 0;
    while ((q.size() != 0 || !req_ready) && n < 500) begin
      @(posedge clk);
      #1;
      if (rnd) dst_ready = 1'($urandom_range(0, 1));
      n++;
    end
    if (n >= 500) chk("idle_timeout", 1, 0);
    dst_ready = 1'b1;
  endtask

  initial begin
    int n;
    int b0;
    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    req_mask  = '0;
    dst_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_dst_valid", dst_valid, 0);
    chk("rst_dst_last", dst_last, 0);
    chk("rst_empty", empty, 0);
    chk("rst_dst_x", dst_x, 0);
    chk("rst_dst_addr", dst_addr, 0);
    rst = 1'b0;

    // Unicast
    push_beat(2, 1, 1);
    send(mk(2, 1), '0);
    wait_idle(0);

    // Y broadcast, row 3 skipped
    push_beat(1, 0, 0);
    push_beat(1, 1, 0);
    push_beat(1, 2, 1);
    send(mk(1, 0), MaskY);
    n = 0;
    while (!req_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ybc_cycles", n, 5);
    wait_idle(0);

    // Full broadcast, mask bits outside the fields set
    push_full();
    send(mk(0, 0), 48'hFFFF_FFFF_FFFF);
    wait_idle(0);

    // Full broadcast under random backpressure
    push_full();
    send(mk(0, 0), MaskXY);
    dst_ready = 1'b0;
    wait_idle(1);

    // Every candidate out of range
    push_empty();
    send(mk(0, 3), '0);
    wait_idle(0);
    @(posedge clk);
    #1;

    // Reset after the 4th beat of a full broadcast
    push_full();
    b0 = beats;
    send(mk(0, 0), MaskXY);
    n = 0;
    while (beats < b0 + 4 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 100) chk("reset_wait_timeout", 1, 0);
    chk("beats_before_reset", beats - b0, 4);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", dst_valid, 0);
    chk("midrst_ready", req_ready, 1);
    q.delete();
    rst = 1'b0;

    push_beat(2, 1, 1);
    send(mk(2, 1), '0);
    wait_idle(0);

    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 64'(q.size()), 0);
    chk("total_beats", 64'(beats), 33);
    chk("total_empties", 64'(empties), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
